uart_tx_fifo: RTL and testbench

UART transmitter with a small write FIFO and an RS-485-style driver-enable output. It is the transmit end of the SoC's serial link and the counterpart to the on-chip UART receiver. A host-side bench or peer tile instance uses it to send command bytes into the SoC's cio_rx_i pin. Its cio_tx_o and cio_tx_en_o outputs map directly to a pad and pad enable.

---
 rtl/uart_tx_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small write FIFO and an RS-485-style
// driver-enable output. Bytes are queued through a valid/ready write port.
// The serializer sends a start bit, DATA_W data bits LSB first, an optional
// parity bit and then one or two stop bits.
//
// Handshake: a write happens on a rising clk_i edge where wvalid_i and
// wready_o are both 1. wready_o is !full. It is decoded from registered state
// only, so it never depends combinationally on wvalid_i or on a same-cycle pop.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_div_i              bit period minus one, in clk_i cycles
//   cfg_parity_en_i        1 = append parity bit
//   cfg_parity_odd_i       1 = odd parity, 0 = even parity
//   cfg_stop2_i            1 = two stop bits
//   tx_enable_i            1 = allowed to launch new frames
//   wdata_i/wvalid_i/wready_o  write port into the FIFO
//   fifo_level_o           number of occupied FIFO entries
//   busy_o                 a frame is in progress
//   cio_tx_o, cio_tx_en_o  serial line (idles high) and pad driver enable
//   dbg_state_o            current FSM state, for debug and checkers
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [DIV_W-1:0]                 cfg_div_i,
  input  logic                             cfg_parity_en_i,
  input  logic                             cfg_parity_odd_i,
  input  logic                             cfg_stop2_i,
  input  logic                             tx_enable_i,
  input  logic [DATA_W-1:0]                wdata_i,
  input  logic                             wvalid_i,
  output logic                             wready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             busy_o,
  output logic                             cio_tx_o,
  output logic                             cio_tx_en_o,
  output logic [2:0]                       dbg_state_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign fifo_empty = (level_q == '0);
  assign wready_o   = (level_q != FULL_LVL);
  assign push       = wvalid_i && wready_o;
  assign head       = mem_q[rd_ptr_q];

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Depth is a power of two, so pointers wrap naturally on overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q;
  logic [DIV_W-1:0]  baud_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              par_en_q;
  logic              par_odd_q;
  logic              stop2_q;
  logic              stop_cnt_q;
  logic              tx_q;
  logic              tx_en_q;
  logic              bit_done;
  logic              frame_end;
  logic              parity_bit;

  assign bit_done   = (baud_cnt_q == '0);
  // The last stop bit is ending. With two stop bits, stop_cnt_q marks the second one.
  assign frame_end  = (state_q == S_STOP) && bit_done && (!stop2_q || stop_cnt_q);
  // A new frame launches from IDLE, or straight out of the last stop bit.
  assign pop        = !fifo_empty && tx_enable_i &&
                      ((state_q == S_IDLE) || frame_end);
  assign parity_bit = (^data_q) ^ par_odd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_en_q    <= 1'b0;
    end else if (pop) begin
      // Launch: pop the head entry and freeze the config for this frame.
      state_q    <= S_START;
      baud_cnt_q <= cfg_div_i;
      div_q      <= cfg_div_i;
      bit_cnt_q  <= '0;
      shift_q    <= head;
      data_q     <= head;
      par_en_q   <= cfg_parity_en_i;
      par_odd_q  <= cfg_parity_odd_i;
      stop2_q    <= cfg_stop2_i;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b0;
      tx_en_q    <= 1'b1;
    end else if (state_q == S_IDLE) begin
      tx_q    <= 1'b1;
      tx_en_q <= 1'b0;
    end else if (!bit_done) begin
      baud_cnt_q <= baud_cnt_q - DIV_W'(1);
    end else begin
      baud_cnt_q <= div_q;
      case (state_q)
        S_START: begin
          state_q   <= S_DATA;
          bit_cnt_q <= '0;
          tx_q      <= shift_q[0];
          shift_q   <= shift_q >> 1;
        end
        S_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_q <= S_PARITY;
              tx_q    <= parity_bit;
            end else begin
              state_q    <= S_STOP;
              stop_cnt_q <= 1'b0;
              tx_q       <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        S_PARITY: begin
          state_q    <= S_STOP;
          stop_cnt_q <= 1'b0;
          tx_q       <= 1'b1;
        end
        S_STOP: begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_q <= 1'b1;
          end else begin
            // Frame done and nothing to launch: release the line driver.
            state_q <= S_IDLE;
            tx_en_q <= 1'b0;
          end
          tx_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          tx_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_level_o = level_q;
  assign busy_o       = tx_en_q;
  assign cio_tx_o     = tx_q;
  assign cio_tx_en_o  = tx_en_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed testbench for uart_tx_fifo. Expected line values
// are expanded per clock cycle into exp_q and compared on the falling edge.
module tb_uart_tx_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_stop2;
  logic        tx_enable;
  logic [7:0]  wdata;
  logic        wvalid;
  logic        wready;
  logic [2:0]  fifo_level;
  logic        busy;
  logic        cio_tx;
  logic        cio_tx_en;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int w;
  int bad;
  int n;

  logic [0:0] exp_q[$];

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cfg_div_i        (cfg_div),
    .cfg_parity_en_i  (cfg_par_en),
    .cfg_parity_odd_i (cfg_par_odd),
    .cfg_stop2_i      (cfg_stop2),
    .tx_enable_i      (tx_enable),
    .wdata_i          (wdata),
    .wvalid_i         (wvalid),
    .wready_o         (wready),
    .fifo_level_o     (fifo_level),
    .busy_o           (busy),
    .cio_tx_o         (cio_tx),
    .cio_tx_en_o      (cio_tx_en),
    .dbg_state_o      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Expected-line builders
  // ---------------------------------------------------------------------------
  // Bit 0 of 'bits' is the first bit on the line.
  task automatic add_bits(input logic [15:0] bits, input int nbits, input int div);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c <= div; c++) exp_q.push_back(bits[i]);
    end
  endtask

  // par_bit is supplied by the caller, worked out by hand for each vector.
  task automatic add_frame(input logic [7:0] d, input int div, input bit has_par,
                           input bit par_bit, input bit stop2);
    logic [15:0] bits;
    int nb;
    bits = '0;
    bits[8:1] = d;
    nb = 9;
    if (has_par) begin
      bits[nb] = par_bit;
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (stop2) begin
      bits[nb] = 1'b1;
      nb++;
    end
    add_bits(bits, nb, div);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic push_byte(input logic [7:0] d);
    int k;
    k = 0;
    @(negedge clk);
    wdata  = d;
    wvalid = 1'b1;
    while (!wready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!wready) check("push_timeout", 32'(wready), 32'd1);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
  endtask

  // Wait (bounded) for the driver enable, then compare every queued cycle.
  task automatic run_frames(output int waited);
    logic [0:0] e;
    waited = 0;
    while (!cio_tx_en && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!cio_tx_en) begin
      check("en_timeout", 32'(cio_tx_en), 32'd1);
      exp_q.delete();
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_bit", 32'(cio_tx), 32'(e));
        check("tx_en", 32'(cio_tx_en), 32'd1);
        check("busy", 32'(busy), 32'd1);
        @(negedge clk);
      end
      check("en_after", 32'(cio_tx_en), 32'd0);
      check("tx_after", 32'(cio_tx), 32'd1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    wvalid      = 1'b1;
    wdata       = 8'hFF;
    tx_enable   = 1'b1;
    cfg_div     = 16'd3;
    cfg_par_en  = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b0;

    // Reset held with a write request pending.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(cio_tx), 32'd1);
    check("rst_en", 32'(cio_tx_en), 32'd0);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    wvalid = 1'b0;
    rst_n  = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!cio_tx || cio_tx_en) bad++;
    end
    check("idle_100", 32'(bad), 32'd0);
    check("idle_level", 32'(fifo_level), 32'd0);

    // Basic frame 0xA5, div 3: line 0,1,0,1,0,0,1,0,1,1 (first bit in bit 0).
    // Config is disturbed mid-frame and must not affect it.
    add_bits(16'h034A, 10, 3);
    push_byte(8'hA5);
    fork
      run_frames(w);
      begin
        repeat (10) @(negedge clk);
        cfg_div    = 16'd7;
        cfg_par_en = 1'b1;
        cfg_stop2  = 1'b1;
      end
    join
    check("launch_latency", 32'(w), 32'd2);
    cfg_div    = 16'd0;
    cfg_stop2  = 1'b0;

    // Parity on 0x07 (three ones): even -> 1, odd -> 0.
    cfg_par_odd = 1'b0;
    add_frame(8'h07, 0, 1'b1, 1'b1, 1'b0);
    push_byte(8'h07);
    run_frames(w);
    cfg_par_odd = 1'b1;
    add_frame(8'h07, 0, 1'b1, 1'b0, 1'b0);
    push_byte(8'h07);
    run_frames(w);
    // Two stop bits: 12-cycle frame.
    cfg_par_odd = 1'b0;
    cfg_stop2   = 1'b1;
    add_frame(8'h07, 0, 1'b1, 1'b1, 1'b1);
    push_byte(8'h07);
    run_frames(w);

    // FIFO full and back-to-back drain.
    cfg_div    = 16'd1;
    cfg_par_en = 1'b0;
    cfg_stop2  = 1'b0;
    tx_enable  = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    @(negedge clk);
    check("full_wready", 32'(wready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);
    wdata  = 8'h55;
    wvalid = 1'b1;
    repeat (5) @(negedge clk);
    check("full_held_level", 32'(fifo_level), 32'd4);
    check("full_held_tx", 32'(cio_tx), 32'd1);
    check("full_held_en", 32'(cio_tx_en), 32'd0);
    wvalid = 1'b0;
    add_frame(8'h11, 1, 1'b0, 1'b0, 1'b0);
    add_frame(8'h22, 1, 1'b0, 1'b0, 1'b0);
    add_frame(8'h33, 1, 1'b0, 1'b0, 1'b0);
    add_frame(8'h44, 1, 1'b0, 1'b0, 1'b0);
    tx_enable = 1'b1;
    run_frames(w);
    check("drain_level", 32'(fifo_level), 32'd0);

    // Enable dropped during DATA of the first of two queued bytes.
    tx_enable = 1'b0;
    push_byte(8'h3C);
    push_byte(8'hC3);
    @(negedge clk);
    check("drop_level2", 32'(fifo_level), 32'd2);
    add_frame(8'h3C, 1, 1'b0, 1'b0, 1'b0);
    tx_enable = 1'b1;
    fork
      run_frames(w);
      begin
        n = 0;
        while (!cio_tx_en && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (6) @(negedge clk);
        tx_enable = 1'b0;
      end
    join
    check("drop_level1", 32'(fifo_level), 32'd1);
    repeat (20) @(negedge clk);
    check("drop_idle_tx", 32'(cio_tx), 32'd1);
    check("drop_idle_en", 32'(cio_tx_en), 32'd0);
    check("drop_idle_level", 32'(fifo_level), 32'd1);
    add_frame(8'hC3, 1, 1'b0, 1'b0, 1'b0);
    tx_enable = 1'b1;
    run_frames(w);
    check("resume_level", 32'(fifo_level), 32'd0);

    // Push and pop on the same edge keep the level unchanged.
    cfg_div   = 16'd0;
    tx_enable = 1'b0;
    push_byte(8'h01);
    @(negedge clk);
    check("pp_level_before", 32'(fifo_level), 32'd1);
    tx_enable = 1'b1;
    wdata     = 8'h02;
    wvalid    = 1'b1;
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    @(negedge clk);
    check("pp_level", 32'(fifo_level), 32'd1);
    add_frame(8'h01, 0, 1'b0, 1'b0, 1'b0);
    add_frame(8'h02, 0, 1'b0, 1'b0, 1'b0);
    run_frames(w);
    check("pp_level_after", 32'(fifo_level), 32'd0);

    // Reset pulsed during PARITY of 0x5A (four ones, even parity 0).
    cfg_div     = 16'd1;
    cfg_par_en  = 1'b1;
    cfg_par_odd = 1'b0;
    tx_enable   = 1'b0;
    push_byte(8'h5A);
    push_byte(8'h81);
    tx_enable = 1'b1;
    n = 0;
    while (!cio_tx_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (18) @(negedge clk);
    check("parity_bit_5a", 32'(cio_tx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(cio_tx), 32'd1);
    check("arst_en", 32'(cio_tx_en), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_wready", 32'(wready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!cio_tx || cio_tx_en || fifo_level != 3'd0) bad++;
    end
    check("arst_no_residual", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
